sd_wb_master_arb: RTL and testbench
===================================

Name: sd_wb_master_arb

Overview:
- Shares the SD controller's single Wishbone master port between two requesters: the RX filler (writes card data to memory) and the TX filler (reads memory for card writes).
- Grants whole Wishbone cycles, from cyc assertion to cyc drop, to one requester at a time. Arbitration is round-robin.
- Sits between both fillers and the top-level m_wb_* master bus.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT_CYCLES, 256, ack timeout limit; used only with SD_ARB_TIMEOUT_EN; legal range 2..65535

Ports:
- clk  in  1  system/Wishbone clock
- rst  in  1  synchronous active-high reset
- rx_adr_i  in  AW  RX requester address
- rx_dat_i  in  DW  RX write data
- rx_we_i / rx_cyc_i / rx_stb_i  in  1 each  RX Wishbone controls
- rx_cti_i  in  3  RX cycle type
- rx_bte_i  in  2  RX burst type
- rx_ack_o  out  1  ack routed to RX
- tx_adr_i  in  AW  TX requester address
- tx_we_i / tx_cyc_i / tx_stb_i  in  1 each  TX Wishbone controls
- tx_cti_i  in  3  TX cycle type
- tx_bte_i  in  2  TX burst type
- tx_dat_o  out  DW  read data routed to TX
- tx_ack_o  out  1  ack routed to TX
- m_wb_adr_o  out  AW  shared bus address
- m_wb_dat_o  out  DW  shared bus write data
- m_wb_we_o / m_wb_cyc_o / m_wb_stb_o  out  1 each  shared bus controls
- m_wb_cti_o  out  3  shared bus cycle type
- m_wb_bte_o  out  2  shared bus burst type
- m_wb_dat_i  in  DW  shared bus read data
- m_wb_ack_i  in  1  shared bus ack
- grant_o  out  2  one-hot owner: bit0 = RX, bit1 = TX
- err_o  out  2  one-cycle timeout pulse per requester: bit0 = RX, bit1 = TX

Behaviour:
- State machine states: IDLE, OWN_RX, OWN_TX, ABORT. ABORT exists only with the macro.
- Reset (synchronous, rst=1 at a clk edge):
  - state = IDLE; last-grant register = TX, so RX wins the first contention.
  - grant_o = 0, err_o = 0.
  - All m_wb_* outputs, rx_ack_o, tx_ack_o and tx_dat_o read 0.
  - Reset mid-transfer: m_wb_cyc_o/stb_o drop the cycle after the reset edge. No ack is forwarded after that edge.
- IDLE transitions:
  - Only rx_cyc_i = 1 → OWN_RX.
  - Only tx_cyc_i = 1 → OWN_TX.
  - Both = 1 → the requester not granted last; last-grant register updates on every grant.
  - Neither → stay in IDLE.
- Grant latency: requester cyc_i seen high at edge N → grant_o and m_wb_cyc_o high from cycle N+1.
- Bus mux:
  - In OWN_x, all m_wb_* outputs are a combinational pass-through of requester x's signals.
  - In IDLE/ABORT, all m_wb_* outputs are 0.
  - m_wb_dat_o is 0 while TX owns the bus.
- Ack/data routing:
  - m_wb_ack_i goes only to the owner's ack output, combinationally; the non-owner ack is always 0.
  - tx_dat_o = m_wb_dat_i while in OWN_TX, else 0.
- Release:
  - Owner drops cyc_i → state returns to IDLE at the next edge.
  - At least one idle bus cycle separates consecutive grants.
  - A waiting requester is granted on the cycle after IDLE.
- Bursts: the owner keeps the bus for any cti/bte burst as long as cyc_i stays high. The arbiter does not pre-empt.
- Simultaneous events: ack arriving in the same cycle the owner drops cyc → ack still forwarded; release proceeds normally.
- Requester protocol: a requester must not assert stb_i without cyc_i. If it does, the stb is ignored until a grant.

Optional Feature:
- Macro: SD_ARB_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter clears on grant and on each m_wb_ack_i.
  - It increments each cycle that m_wb_stb_o = 1 and m_wb_ack_i = 0.
  - When the count reaches TIMEOUT_CYCLES-1 with no ack: next state is ABORT, bus outputs are 0, and the owner's err_o bit pulses for exactly that one ABORT cycle. Next state is IDLE.
  - The aborted requester is masked from arbitration until its cyc_i has been seen low for one cycle.
- Without the macro: no counter, err_o is tied to 0, the ABORT state does not exist, and the arbiter waits for an ack indefinitely.

Test Plan:
- Reset, then rx_cyc_i = rx_stb_i = 1 with rx_adr_i = 0x1000 → cycle+1: grant_o = 01, m_wb_adr_o = 0x1000, m_wb_we_o = rx_we_i. Ack at cycle 3 → rx_ack_o = 1, tx_ack_o = 0.
- RX and TX both raise cyc in the same cycle after reset → RX granted first. RX drops cyc → one idle cycle, then grant_o = 10. Next simultaneous request → TX is last, so RX wins again.
- TX read owning the bus, m_wb_dat_i = 0xDEADBEEF with ack → tx_dat_o = 0xDEADBEEF and tx_ack_o = 1 in the same cycle; m_wb_dat_o = 0.
- RX holds cyc for a 4-beat burst (cti = 010, then 111) while TX requests → TX waits; TX granted 2 cycles after RX drops cyc.
- rst asserted while RX owns the bus with stb high → m_wb_cyc_o = 0 the next cycle, grant_o = 00, RX wins the next contention.
- With SD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, TX stb never acked → err_o = 10 for one cycle after 8 unacked stb cycles; TX not re-granted until tx_cyc_i drops. Without the macro → the bus stays granted and err_o = 0.

Source files
------------

// File: rtl/sd_wb_master_arb.sv
`default_nettype none
// ============================================================================
// Module      : sd_wb_master_arb
// Description : Round-robin owner of the SD controller's single Wishbone
//               master port, shared by the RX filler and the TX filler.
//               Optional ack timeout/abort enabled by SD_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_wb_master_arb #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rx_adr_i,
  input  logic [DW-1:0] rx_dat_i,
  input  logic          rx_we_i,
  input  logic          rx_cyc_i,
  input  logic          rx_stb_i,
  input  logic [2:0]    rx_cti_i,
  input  logic [1:0]    rx_bte_i,
  output logic          rx_ack_o,
  input  logic [AW-1:0] tx_adr_i,
  input  logic          tx_we_i,
  input  logic          tx_cyc_i,
  input  logic          tx_stb_i,
  input  logic [2:0]    tx_cti_i,
  input  logic [1:0]    tx_bte_i,
  output logic [DW-1:0] tx_dat_o,
  output logic          tx_ack_o,
  output logic [AW-1:0] m_wb_adr_o,
  output logic [DW-1:0] m_wb_dat_o,
  output logic          m_wb_we_o,
  output logic          m_wb_cyc_o,
  output logic          m_wb_stb_o,
  output logic [2:0]    m_wb_cti_o,
  output logic [1:0]    m_wb_bte_o,
  input  logic [DW-1:0] m_wb_dat_i,
  input  logic          m_wb_ack_i,
  output logic [1:0]    grant_o,
  output logic [1:0]    err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_RX = 2'd1,
    OWN_TX = 2'd2
`ifdef SD_ARB_TIMEOUT_EN
    ,
    ABORT  = 2'd3
`endif
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last_tx;
  logic   w_rx_req;
  logic   w_tx_req;

`ifdef SD_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic [1:0]  r_mask;
  logic        w_expire;

  // An aborted requester stays out of arbitration until it lets go of cyc.
  assign w_rx_req = rx_cyc_i & ~r_mask[0];
  assign w_tx_req = tx_cyc_i & ~r_mask[1];
  assign w_expire = m_wb_stb_o && !m_wb_ack_i &&
                    (r_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic [15:0] w_unused_timeout;

  assign w_unused_timeout = 16'(TIMEOUT_CYCLES);
  assign w_rx_req         = rx_cyc_i;
  assign w_tx_req         = tx_cyc_i;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_rx_req && (!w_tx_req || r_last_tx)) w_next = OWN_RX;
        else if (w_tx_req)                        w_next = OWN_TX;
      end
      OWN_RX: begin
        if (!rx_cyc_i) w_next = IDLE;
`ifdef SD_ARB_TIMEOUT_EN
        else if (w_expire) w_next = ABORT;
`endif
      end
      OWN_TX: begin
        if (!tx_cyc_i) w_next = IDLE;
`ifdef SD_ARB_TIMEOUT_EN
        else if (w_expire) w_next = ABORT;
`endif
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last_tx <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next == OWN_RX)      r_last_tx <= 1'b0;
      else if (w_next == OWN_TX) r_last_tx <= 1'b1;
    end
  end

  always_comb begin
    m_wb_adr_o = '0;
    m_wb_dat_o = '0;
    m_wb_we_o  = 1'b0;
    m_wb_cyc_o = 1'b0;
    m_wb_stb_o = 1'b0;
    m_wb_cti_o = 3'b000;
    m_wb_bte_o = 2'b00;
    rx_ack_o   = 1'b0;
    tx_ack_o   = 1'b0;
    tx_dat_o   = '0;
    grant_o    = 2'b00;
    err_o      = 2'b00;
    case (r_state)
      OWN_RX: begin
        m_wb_adr_o = rx_adr_i;
        m_wb_dat_o = rx_dat_i;
        m_wb_we_o  = rx_we_i;
        m_wb_cyc_o = rx_cyc_i;
        m_wb_stb_o = rx_stb_i;
        m_wb_cti_o = rx_cti_i;
        m_wb_bte_o = rx_bte_i;
        rx_ack_o   = m_wb_ack_i;
        grant_o    = 2'b01;
      end
      OWN_TX: begin
        m_wb_adr_o = tx_adr_i;
        m_wb_we_o  = tx_we_i;
        m_wb_cyc_o = tx_cyc_i;
        m_wb_stb_o = tx_stb_i;
        m_wb_cti_o = tx_cti_i;
        m_wb_bte_o = tx_bte_i;
        tx_ack_o   = m_wb_ack_i;
        tx_dat_o   = m_wb_dat_i;
        grant_o    = 2'b10;
      end
`ifdef SD_ARB_TIMEOUT_EN
      // The last-grant register still names the requester that was aborted.
      ABORT: err_o = r_last_tx ? 2'b10 : 2'b01;
`endif
      default: ;
    endcase
  end

`ifdef SD_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_mask <= 2'b00;
    end else begin
      if ((grant_o == 2'b00) || m_wb_ack_i) r_cnt <= '0;
      else if (m_wb_stb_o)                  r_cnt <= r_cnt + 16'd1;

      if ((w_next == ABORT) && (r_state == OWN_RX)) r_mask[0] <= 1'b1;
      else if (!rx_cyc_i)                           r_mask[0] <= 1'b0;

      if ((w_next == ABORT) && (r_state == OWN_TX)) r_mask[1] <= 1'b1;
      else if (!tx_cyc_i)                           r_mask[1] <= 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sd_wb_master_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_wb_master_arb
// Description : Directed self-checking bench for sd_wb_master_arb.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sd_wb_master_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rx_adr_i, rx_dat_i, tx_adr_i, m_wb_dat_i;
  logic        rx_we_i, rx_cyc_i, rx_stb_i, tx_we_i, tx_cyc_i, tx_stb_i;
  logic [2:0]  rx_cti_i, tx_cti_i;
  logic [1:0]  rx_bte_i, tx_bte_i;
  logic        m_wb_ack_i;
  logic        rx_ack_o, tx_ack_o;
  logic [31:0] tx_dat_o, m_wb_adr_o, m_wb_dat_o;
  logic        m_wb_we_o, m_wb_cyc_o, m_wb_stb_o;
  logic [2:0]  m_wb_cti_o;
  logic [1:0]  m_wb_bte_o, grant_o, err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sd_wb_master_arb #(.AW(32), .DW(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .rx_adr_i(rx_adr_i), .rx_dat_i(rx_dat_i), .rx_we_i(rx_we_i),
    .rx_cyc_i(rx_cyc_i), .rx_stb_i(rx_stb_i), .rx_cti_i(rx_cti_i),
    .rx_bte_i(rx_bte_i), .rx_ack_o(rx_ack_o),
    .tx_adr_i(tx_adr_i), .tx_we_i(tx_we_i), .tx_cyc_i(tx_cyc_i),
    .tx_stb_i(tx_stb_i), .tx_cti_i(tx_cti_i), .tx_bte_i(tx_bte_i),
    .tx_dat_o(tx_dat_o), .tx_ack_o(tx_ack_o),
    .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_we_o(m_wb_we_o),
    .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o), .m_wb_cti_o(m_wb_cti_o),
    .m_wb_bte_o(m_wb_bte_o), .m_wb_dat_i(m_wb_dat_i), .m_wb_ack_i(m_wb_ack_i),
    .grant_o(grant_o), .err_o(err_o)
  );

  // Step to 1ns after the next rising edge; inputs change only here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rx_adr_i = '0; rx_dat_i = '0; rx_we_i = 0; rx_cyc_i = 0; rx_stb_i = 0;
    rx_cti_i = '0; rx_bte_i = '0;
    tx_adr_i = '0; tx_we_i = 0; tx_cyc_i = 0; tx_stb_i = 0;
    tx_cti_i = '0; tx_bte_i = '0;
    m_wb_ack_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    m_wb_dat_i = 32'hA5A5_5A5A;
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", grant_o); end
    total++; if (err_o !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", err_o); end
    total++; if ({m_wb_cyc_o, m_wb_stb_o, m_wb_adr_o} !== 34'd0) begin bad++; $display("FAIL reset_bus got=%h exp=0", {m_wb_cyc_o, m_wb_stb_o, m_wb_adr_o}); end
    total++; if (tx_dat_o !== 32'd0) begin bad++; $display("FAIL reset_txdat got=%h exp=0", tx_dat_o); end
  endtask

  task automatic test_rx_single();
    rx_cyc_i = 1; rx_stb_i = 1; rx_we_i = 1;
    rx_adr_i = 32'h0000_1000; rx_dat_i = 32'h0000_0055;
    #1;
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL rx_latency got=%b exp=00", grant_o); end
    tick();
    total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL rx_grant got=%b exp=01", grant_o); end
    total++; if (m_wb_adr_o !== 32'h1000 || m_wb_we_o !== 1'b1 || m_wb_dat_o !== 32'h55)
      begin bad++; $display("FAIL rx_pass got=%h/%b/%h exp=1000/1/55", m_wb_adr_o, m_wb_we_o, m_wb_dat_o); end
    tick();
    m_wb_ack_i = 1;
    #1;
    total++; if (rx_ack_o !== 1'b1 || tx_ack_o !== 1'b0) begin bad++; $display("FAIL rx_ack got=%b%b exp=10", rx_ack_o, tx_ack_o); end
    tick();
    idle_inputs();
    tick();
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL rx_release got=%b exp=00", grant_o); end
  endtask

  task automatic test_round_robin();
    rst = 1; tick(); rst = 0;
    rx_cyc_i = 1; tx_cyc_i = 1;
    tick();
    total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL rr_first got=%b exp=01", grant_o); end
    rx_cyc_i = 0;
    tick();
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL rr_gap got=%b exp=00", grant_o); end
    tick();
    total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL rr_second got=%b exp=10", grant_o); end
    tx_cyc_i = 0;
    tick();
    rx_cyc_i = 1; tx_cyc_i = 1;
    tick();
    total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL rr_third got=%b exp=01", grant_o); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_tx_read();
    tx_cyc_i = 1; tx_stb_i = 1; tx_we_i = 0; tx_adr_i = 32'h0000_2000;
    rx_dat_i = 32'h0000_1234;
    tick();
    total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL tx_grant got=%b exp=10", grant_o); end
    m_wb_dat_i = 32'hDEAD_BEEF; m_wb_ack_i = 1;
    #1;
    total++; if (tx_dat_o !== 32'hDEAD_BEEF || tx_ack_o !== 1'b1 || rx_ack_o !== 1'b0)
      begin bad++; $display("FAIL tx_read got=%h/%b/%b exp=deadbeef/1/0", tx_dat_o, tx_ack_o, rx_ack_o); end
    total++; if (m_wb_dat_o !== 32'd0 || m_wb_adr_o !== 32'h2000)
      begin bad++; $display("FAIL tx_bus got=%h/%h exp=0/2000", m_wb_dat_o, m_wb_adr_o); end
    tx_cyc_i = 0; tx_stb_i = 0;
    #1;
    total++; if (tx_ack_o !== 1'b1) begin bad++; $display("FAIL tx_ack_on_drop got=%b exp=1", tx_ack_o); end
    tick();
    m_wb_ack_i = 0;
    #1;
    total++; if (grant_o !== 2'b00 || tx_dat_o !== 32'd0) begin bad++; $display("FAIL tx_release got=%b/%h exp=00/0", grant_o, tx_dat_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_burst();
    rx_cyc_i = 1; rx_stb_i = 1; rx_cti_i = 3'b010;
    tick();
    total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL burst_grant got=%b exp=01", grant_o); end
    tx_cyc_i = 1; tx_stb_i = 1;
    for (int i = 0; i < 4; i++) begin
      rx_cti_i = (i == 3) ? 3'b111 : 3'b010;
      m_wb_ack_i = 1;
      #1;
      total++; if (grant_o !== 2'b01 || m_wb_cti_o !== rx_cti_i)
        begin bad++; $display("FAIL burst_beat%0d got=%b/%b exp=01/%b", i, grant_o, m_wb_cti_o, rx_cti_i); end
      tick();
    end
    m_wb_ack_i = 0; rx_cyc_i = 0; rx_stb_i = 0;
    #1;
    total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL burst_hold got=%b exp=01", grant_o); end
    tick();
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL burst_gap got=%b exp=00", grant_o); end
    tick();
    total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL burst_tx got=%b exp=10", grant_o); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    rx_cyc_i = 1; rx_stb_i = 1;
    tick();
    total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL rmid_grant got=%b exp=01", grant_o); end
    rst = 1; m_wb_ack_i = 1;
    tick();
    total++; if (m_wb_cyc_o !== 1'b0 || grant_o !== 2'b00 || rx_ack_o !== 1'b0)
      begin bad++; $display("FAIL rmid_drop got=%b/%b/%b exp=0/00/0", m_wb_cyc_o, grant_o, rx_ack_o); end
    rst = 0; m_wb_ack_i = 0; tx_cyc_i = 1;
    tick();
    total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL rmid_rxwins got=%b exp=01", grant_o); end
    idle_inputs();
    tick(); tick();
  endtask

`ifdef SD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    tx_cyc_i = 1; tx_stb_i = 1;
    tick();
    total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL to_grant got=%b exp=10", grant_o); end
    for (int i = 0; i < 7; i++) tick();
    total++; if (grant_o !== 2'b10 || err_o !== 2'b00) begin bad++; $display("FAIL to_early got=%b/%b exp=10/00", grant_o, err_o); end
    tick();
    total++; if (err_o !== 2'b10 || grant_o !== 2'b00 || m_wb_cyc_o !== 1'b0)
      begin bad++; $display("FAIL to_abort got=%b/%b/%b exp=10/00/0", err_o, grant_o, m_wb_cyc_o); end
    tick();
    total++; if (err_o !== 2'b00) begin bad++; $display("FAIL to_pulse got=%b exp=00", err_o); end
    tick();
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL to_masked got=%b exp=00", grant_o); end
    tx_cyc_i = 0; tx_stb_i = 0;
    tick();
    tx_cyc_i = 1; tx_stb_i = 1;
    tick();
    total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL to_regrant got=%b exp=10", grant_o); end
    idle_inputs();
    tick(); tick();
  endtask
`else
  task automatic test_timeout();
    tx_cyc_i = 1; tx_stb_i = 1;
    tick();
    for (int i = 0; i < 12; i++) tick();
    total++; if (grant_o !== 2'b10 || err_o !== 2'b00 || m_wb_stb_o !== 1'b1)
      begin bad++; $display("FAIL no_timeout got=%b/%b/%b exp=10/00/1", grant_o, err_o, m_wb_stb_o); end
    idle_inputs();
    tick(); tick();
  endtask
`endif

  initial begin
    rst = 1;
    m_wb_dat_i = '0;
    idle_inputs();
    test_reset();
    test_rx_single();
    test_round_robin();
    test_tx_read();
    test_burst();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
